// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state, arbiter FSM state.
// Also holds the default RAM wait timeout used by the memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int MEM_TIMEOUT = 16;

endpackage

// File: rtl/memory_arbiter_access_timer.sv
// Saturating RAM wait counter for the memory arbiter.
// expired flags the cycle in which the count reaches TIMEOUT.
module access_timer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT    = W'(TIMEOUT);
    localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;

    // Count waiting cycles, clear while not serving, hold at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + W'(1);
        end
    end

    // Expired when this waiting cycle takes the count to the limit.
    assign expired = (r_count == LIMIT) ||
                     (enable && (r_count == LIMIT_M1));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins ties; timeouts and RAM errors lock into FAULT until reset.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
);

    state_t r_state;
    state_t w_next;
    logic   w_dreq;
    logic   w_serving;
    logic   w_waiting;
    logic   w_clear;
    logic   w_expired;

    assign w_dreq    = dREN | dWEN;
    assign w_serving = (r_state == DSERV) || (r_state == ISERV);
    assign w_waiting = w_serving && (ramstate != ACCESS);
    assign w_clear   = !w_serving;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (w_clear),
        .enable (w_waiting),
        .expired(w_expired)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a dropped request abandons, then error, hit, timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_next = DSERV;
                end else if (iREN) begin
                    w_next = ISERV;
                end
            end
            DSERV: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (ramstate == ERROR) begin
                    w_next = FAULT;
                end else if (ramstate == ACCESS) begin
                    w_next = IDLE;
                end else if (w_expired) begin
                    w_next = FAULT;
                end
            end
            ISERV: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else if (ramstate == ERROR) begin
                    w_next = FAULT;
                end else if (ramstate == ACCESS) begin
                    w_next = IDLE;
                end else if (w_expired) begin
                    w_next = FAULT;
                end
            end
            FAULT: begin
                w_next = FAULT;
            end
        endcase
    end

    // RAM strobes, hit pulses and returned data for the current state.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        mem_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
            end
            DSERV: begin
                ramaddr  = daddr;
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramstore = dstore;
                if (w_dreq && (ramstate == ACCESS)) begin
                    dhit  = 1'b1;
                    dload = ramload;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (iREN && (ramstate == ACCESS)) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
            end
            FAULT: begin
                mem_err = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 16;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      mem_err;

    always #5 CLK = ~CLK;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .ihit    (ihit),
        .dhit    (dhit),
        .iload   (iload),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .mem_err (mem_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what the arbiter is busy with and how long it has waited.
    // owner: 0 none, 1 data transaction, 2 fetch, 3 locked out by fault.
    int   m_owner;
    int   m_waited;
    logic e_ihit;
    logic e_dhit;
    int   n_ihit;
    int   n_dhit;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        word_t ea, es, eil, edl;
        logic  er, ew, ee;
        ea = '0; es = '0; eil = '0; edl = '0;
        er = 1'b0; ew = 1'b0; ee = 1'b0;
        e_ihit = 1'b0;
        e_dhit = 1'b0;
        if (m_owner == 1) begin
            ea = daddr;
            es = dstore;
            er = dREN;
            ew = dWEN;
            if ((dREN || dWEN) && ramstate == ACCESS) begin
                e_dhit = 1'b1;
                edl    = ramload;
            end
        end else if (m_owner == 2) begin
            ea = iaddr;
            er = 1'b1;
            if (iREN && ramstate == ACCESS) begin
                e_ihit = 1'b1;
                eil    = ramload;
            end
        end else if (m_owner == 3) begin
            ee = 1'b1;
        end
        chk("strobes", {30'd0, ramREN, ramWEN}, {30'd0, er, ew});
        chk("ramaddr", ramaddr, ea);
        chk("ramstore", ramstore, es);
        chk("hits", {30'd0, ihit, dhit}, {30'd0, e_ihit, e_dhit});
        chk("iload", iload, eil);
        chk("dload", dload, edl);
        chk("mem_err", {31'd0, mem_err}, {31'd0, ee});
        if (ihit) n_ihit++;
        if (dhit) n_dhit++;
    endtask

    task automatic model_update();
        logic req;
        if (!nRST) begin
            m_owner  = 0;
            m_waited = 0;
        end else if (m_owner == 0) begin
            if (dREN || dWEN) begin
                m_owner  = 1;
                m_waited = 0;
            end else if (iREN) begin
                m_owner  = 2;
                m_waited = 0;
            end
        end else if (m_owner != 3) begin
            req = (m_owner == 1) ? (dREN || dWEN) : iREN;
            if (!req) begin
                m_owner = 0;
            end else if (ramstate == ERROR) begin
                m_owner = 3;
            end else if (ramstate == ACCESS) begin
                m_owner = 0;
            end else begin
                m_waited++;
                if (m_waited >= TO) m_owner = 3;
            end
        end
    endtask

    // One clock: check mid-cycle, update model on posedge, end at negedge.
    task automatic step();
        #2 check_out();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; iaddr = '0;
        dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        m_owner  = 0;
        m_waited = 0;
        step();
        nRST = 1'b1;
    endtask

    initial begin
        int r;
        nRST = 1'b0;
        m_owner = 0; m_waited = 0;
        idle_inputs();
        @(negedge CLK);
        #1 chk("reset_err", {31'd0, mem_err}, 32'd0);
        chk("reset_ren", {31'd0, ramREN}, 32'd0);
        do_reset();

        // Fetch with two BUSY cycles then ACCESS.
        n_ihit = 0;
        iREN = 1'b1; iaddr = 32'h0000_0004;
        ramstate = BUSY; ramload = 32'h2001_0005;
        step();
        step();
        step();
        ramstate = ACCESS;
        #1 chk("f_addr", ramaddr, 32'h4);
        chk("f_iload", iload, 32'h2001_0005);
        step();
        iREN = 1'b0; ramstate = FREE;
        step();
        chk("f_nhit", n_ihit, 1);

        // Simultaneous store and fetch: data first, then fetch.
        n_ihit = 0; n_dhit = 0;
        iREN = 1'b1; iaddr = 32'h40;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramstate = ACCESS; ramload = 32'h1234_5678;
        step();
        #1 chk("s_wen", {31'd0, ramWEN}, 32'd1);
        chk("s_dhit", {31'd0, dhit}, 32'd1);
        chk("s_store", ramstore, 32'hDEAD_BEEF);
        step();
        dWEN = 1'b0;
        step();
        #1 chk("s_ihit", {31'd0, ihit}, 32'd1);
        chk("s_iaddr", ramaddr, 32'h40);
        step();
        iREN = 1'b0;
        step();
        chk("s_counts", {n_ihit[15:0], n_dhit[15:0]}, {16'd1, 16'd1});

        // Load with RAM held BUSY runs into the timeout.
        n_dhit = 0;
        dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
        step();
        for (int k = 1; k <= TO; k++) begin
            #1 chk("t_wait_err", {31'd0, mem_err}, 32'd0);
            step();
        end
        #1 chk("t_fault", {31'd0, mem_err}, 32'd1);
        chk("t_ren", {31'd0, ramREN}, 32'd0);
        ramstate = ACCESS;
        step();
        step();
        chk("t_nhit", n_dhit, 0);
        idle_inputs();
        do_reset();

        // ERROR during a fetch.
        n_ihit = 0;
        iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
        step();
        step();
        ramstate = ERROR;
        step();
        ramstate = ACCESS;
        #1 chk("e_fault", {31'd0, mem_err}, 32'd1);
        step();
        chk("e_nhit", n_ihit, 0);
        idle_inputs();
        do_reset();

        // Asynchronous reset in the middle of a BUSY load.
        n_dhit = 0;
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        step();
        step();
        #1 nRST = 1'b0;
        m_owner = 0; m_waited = 0;
        #1 chk("a_ren", {31'd0, ramREN}, 32'd0);
        chk("a_addr", ramaddr, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        step();
        ramstate = ACCESS; ramload = 32'hCAFE_0001;
        #1 chk("a_dload", dload, 32'hCAFE_0001);
        step();
        dREN = 1'b0; ramstate = FREE;
        step();
        chk("a_nhit", n_dhit, 1);

        // Load abandoned after one BUSY cycle.
        n_dhit = 0;
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        step();
        step();
        dREN = 1'b0;
        step();
        #1 chk("d_ren", {31'd0, ramREN}, 32'd0);
        chk("d_err", {31'd0, mem_err}, 32'd0);
        step();
        chk("d_nhit", n_dhit, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if (e_dhit) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else if (!(dREN || dWEN)) begin
                if ($urandom_range(3) == 0) begin
                    if ($urandom_range(1) == 0) dREN = 1'b1;
                    else dWEN = 1'b1;
                    daddr  = $urandom;
                    dstore = $urandom;
                end
            end else if ($urandom_range(24) == 0) begin
                dREN = 1'b0; dWEN = 1'b0;
            end
            if (e_ihit) begin
                iREN = 1'b0;
            end else if (!iREN) begin
                if ($urandom_range(2) == 0) begin
                    iREN  = 1'b1;
                    iaddr = $urandom;
                end
            end else if ($urandom_range(24) == 0) begin
                iREN = 1'b0;
            end
            r = $urandom_range(99);
            if (r < 2) ramstate = ERROR;
            else if (r < 35) ramstate = ACCESS;
            else if (r < 85) ramstate = BUSY;
            else ramstate = FREE;
            ramload = $urandom;
            if (m_owner == 3 && $urandom_range(7) == 0) begin
                do_reset();
            end else if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
